pea_cmd_scheduler: RTL
======================

// Module: pea_cmd_scheduler
// PURPOSE
//  Command sequencer for the Polynomial Evaluation Accelerator (PEA) top level.
//  - Pops control tokens and decodes them.
//  - Streams coefficient and x tokens from the Data Input FIFO into the coefficient store and evaluation core.
//  - Writes results to the Result Output FIFO and one status token per command to the Status Output FIFO.
//  - Owns the slot valid/degree table. Performs no arithmetic.
// PARAMETERS
//  word_size    16    token width; the result is 2*word_size
//  buffer_size  1024  words per FIFO; pop/free-space width PW = log2(buffer_size)
// PORTS
//  clk                input   1      rising-edge clock
//  rst                input   1      asynchronous reset, active-low
//  control_in         input   16     control token: [15:8] opcode, [7:5] arg1 = slot, [4:0] arg2 = n
//  control_pop        input   PW     Control Input FIFO population
//  control_rd_en      output  1      control pop strobe
//  data_in            input   16     data token (signed)
//  data_pop           input   PW     Data Input FIFO population
//  data_rd_en         output  1      data pop strobe
//  result_free_space  input   PW     Result Output FIFO free words
//  result_wr_en       output  1      result push strobe
//  result_out         output  32     registered result token
//  status_free_space  input   PW     Status Output FIFO free words
//  status_wr_en       output  1      status push strobe
//  status_out         output  16     status token: [15:8] opcode, [7:5] slot, [4:2] 0, [1:0] code
//  coef_wr_en         output  1      coefficient store write strobe
//  coef_slot          output  3      coefficient store slot
//  coef_idx           output  5      coefficient index (power of x)
//  coef_wdata         output  16     coefficient value
//  eval_start         output  1      one-cycle start pulse to the evaluation core
//  eval_slot          output  3      slot to evaluate
//  eval_degree        output  5      degree of that slot
//  eval_x             output  16     x operand; held stable from start until done
//  eval_done          input   1      core finished; eval_result valid this cycle
//  eval_result        input   32     core result
//  busy               output  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=0, async):
//   - FSM goes to IDLE.
//   - Every output and the internal registers (table, counters, latched command) go to 0.
//   - Any in-flight command is abandoned. eval_done outside EVP_RUN is ignored.
//  FIFO read: data for a strobe is valid on the cycle after the strobe. All strobes are 1-cycle Moore outputs.
//  Opcodes: 8'h01 STP (store), 8'h02 EVP (evaluate), 8'h03 CLR (clear table). Any other opcode is BAD.
//  Status codes: 2'b00 OK, 2'b01 bad opcode, 2'b10 slot not loaded.
//  Fetch and decode:
//   - IDLE -> FETCH when control_pop != 0; control_rd_en=1 in FETCH.
//   - DECODE latches opcode, slot and n from control_in.
//   - DECODE dispatches: STP -> STP_WAIT, EVP -> EVP_WAIT or DISC, CLR -> STATUS, BAD -> STATUS.
//  STP (degree n, needs n+1 tokens):
//   - STP_WAIT holds until data_pop >= n+1 (n zero-extended, 6-bit compare). No partial loads.
//   - Loop per k = 0..n:
//     - STP_RD: data_rd_en=1.
//     - STP_WR: coef_wr_en=1, coef_idx=k, coef_wdata=data_in.
//   - Each coefficient takes 2 cycles.
//   - After k=n: table[slot] = {valid=1, degree=n} -> STATUS (OK).
//   - Re-STP of a loaded slot overwrites it; the old entry stays valid until the last write.
//  EVP (n x values):
//   - n=0 -> STATUS (OK), no data popped.
//   - Slot invalid -> DISC: pop n tokens, one per 2 cycles, waiting on data_pop>=1 -> STATUS (code 10).
//   - Per x:
//     - EVP_WAIT holds until data_pop>=1 and result_free_space>=1.
//     - EVP_RD: data_rd_en=1.
//     - EVP_GO: eval_x<=data_in; eval_start=1.
//     - EVP_RUN: wait for eval_done; then result_out<=eval_result.
//     - EVP_WB: result_wr_en=1; count+1. If count==n -> STATUS, else -> EVP_WAIT.
//   - Latency from x pop to result push = core latency + 3 cycles.
//  CLR: all valid bits cleared in DECODE -> STATUS (OK).
//  STATUS:
//   - Holds until status_free_space>=1.
//   - Then status_wr_en=1 for one cycle with status_out -> IDLE.
//  A FIFO empty or full condition only stalls the FSM; it never causes an error or a dropped token.
//  Counter k/count is 6 bits, so n=31 (32 coefficients) does not wrap.
//  The next control token is never fetched before the current status token is written.
// STRUCTURE
//  Shared package pea_pkg:
//   - opcode constants (OP_STP, OP_EVP, OP_CLR) and status codes.
//   - token field positions and the log2 function.
//  Sub-module pea_slot_table: 8 x {valid, degree[4:0]}.
//   - Ports: write, clear-all, async read by slot.
//  FSM, counters and output registers stay in this module.
// TESTING
//  1. STP slot2 n=2, data 5,-3,7 -> coef writes (2,0,5),(2,1,-3),(2,2,7); status 16'h0140.
//  2. EVP slot2 n=2, x=1,2 -> 2 eval_start; results pushed in order; status 16'h0240.
//  3. EVP slot4 n=3 with slot4 unloaded -> 3 data pops, no results; status 16'h0282.
//  4. Opcode 8'h7F -> no data pop, status code 01. CLR, then EVP slot2 n=1 -> status code 10.
//  5. result_free_space=0 during EVP n=1 -> no data_rd_en until space=1.
//     status_free_space=0 -> status_wr_en held off.
//  6. rst low in EVP_RUN -> outputs 0, IDLE, table cleared; eval_done one cycle later ignored.

Source files
------------

// File: rtl/pea_cmd_scheduler_pkg.sv
// ============================================================================
// pea_pkg : shared opcodes, status codes, token fields and FSM states. Rev 1.0
// ============================================================================
`default_nettype none

package pea_pkg;

  localparam int OP_W      = 8;
  localparam int SLOT_W    = 3;
  localparam int DEG_W     = 5;
  localparam int CNT_W     = 6;
  localparam int NUM_SLOTS = 8;

  localparam int OP_LSB    = 8;
  localparam int SLOT_LSB  = 5;
  localparam int N_LSB     = 0;

  localparam logic [OP_W-1:0] OP_STP = 8'h01;
  localparam logic [OP_W-1:0] OP_EVP = 8'h02;
  localparam logic [OP_W-1:0] OP_CLR = 8'h03;

  localparam logic [1:0] ST_OK         = 2'b00;
  localparam logic [1:0] ST_BAD_OP     = 2'b01;
  localparam logic [1:0] ST_NOT_LOADED = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_STP_WAIT  = 4'd3,
    S_STP_RD    = 4'd4,
    S_STP_WR    = 4'd5,
    S_EVP_WAIT  = 4'd6,
    S_EVP_RD    = 4'd7,
    S_EVP_GO    = 4'd8,
    S_EVP_RUN   = 4'd9,
    S_EVP_WB    = 4'd10,
    S_DISC_WAIT = 4'd11,
    S_DISC_RD   = 4'd12,
    S_STATUS    = 4'd13,
    S_STAT_WR   = 4'd14
  } pea_state_e;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pea_cmd_scheduler_if.sv
// ============================================================================
// pea_cmd_scheduler_if : FIFO, coefficient-store and core signals. Rev 1.0
// ============================================================================
`default_nettype none

interface pea_cmd_scheduler_if #(
  parameter int WORD_SIZE   = 16,
  parameter int BUFFER_SIZE = 1024
) ();

  localparam int PW = pea_pkg::log2(BUFFER_SIZE);

  logic [15:0]            control_in;
  logic [PW-1:0]          control_pop;
  logic                   control_rd_en;
  logic [WORD_SIZE-1:0]   data_in;
  logic [PW-1:0]          data_pop;
  logic                   data_rd_en;
  logic [PW-1:0]          result_free_space;
  logic                   result_wr_en;
  logic [2*WORD_SIZE-1:0] result_out;
  logic [PW-1:0]          status_free_space;
  logic                   status_wr_en;
  logic [15:0]            status_out;
  logic                   coef_wr_en;
  logic [2:0]             coef_slot;
  logic [4:0]             coef_idx;
  logic [WORD_SIZE-1:0]   coef_wdata;
  logic                   eval_start;
  logic [2:0]             eval_slot;
  logic [4:0]             eval_degree;
  logic [WORD_SIZE-1:0]   eval_x;
  logic                   eval_done;
  logic [2*WORD_SIZE-1:0] eval_result;
  logic                   busy;

  modport master (
    input  control_in, control_pop, data_in, data_pop,
           result_free_space, status_free_space, eval_done, eval_result,
    output control_rd_en, data_rd_en, result_wr_en, result_out,
           status_wr_en, status_out, coef_wr_en, coef_slot, coef_idx,
           coef_wdata, eval_start, eval_slot, eval_degree, eval_x, busy
  );

  modport slave (
    output control_in, control_pop, data_in, data_pop,
           result_free_space, status_free_space, eval_done, eval_result,
    input  control_rd_en, data_rd_en, result_wr_en, result_out,
           status_wr_en, status_out, coef_wr_en, coef_slot, coef_idx,
           coef_wdata, eval_start, eval_slot, eval_degree, eval_x, busy
  );

endinterface

`default_nettype wire

// File: rtl/pea_cmd_scheduler_slot_table.sv
// ============================================================================
// pea_slot_table : 8-entry {valid, degree} table, async read. Rev 1.0
// ============================================================================
`default_nettype none

module pea_slot_table
  import pea_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              wr_en_i,
  input  wire logic [SLOT_W-1:0] wr_slot_i,
  input  wire logic [DEG_W-1:0]  wr_degree_i,
  input  wire logic              clr_i,
  input  wire logic [SLOT_W-1:0] rd_slot_i,
  output logic                   rd_valid_o,
  output logic [DEG_W-1:0]       rd_degree_o
);

  logic [NUM_SLOTS-1:0] valid_w;
  logic [DEG_W-1:0]     degree_w [NUM_SLOTS];

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic             valid_q;
    logic [DEG_W-1:0] degree_q;

    // A write to this slot takes precedence over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q  <= 1'b0;
        degree_q <= '0;
      end else if (wr_en_i && (wr_slot_i == SLOT_W'(i))) begin
        valid_q  <= 1'b1;
        degree_q <= wr_degree_i;
      end else if (clr_i) begin
        valid_q  <= 1'b0;
      end
    end

    assign valid_w[i]  = valid_q;
    assign degree_w[i] = degree_q;
  end

  assign rd_valid_o  = valid_w[rd_slot_i];
  assign rd_degree_o = degree_w[rd_slot_i];

endmodule

`default_nettype wire

// File: rtl/pea_cmd_scheduler.sv
// ============================================================================
// pea_cmd_scheduler : PEA command sequencer (fetch/decode, STP, EVP, CLR). Rev 1.0
// ============================================================================
`default_nettype none

module pea_cmd_scheduler
  import pea_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int BUFFER_SIZE = 1024
) (
  input  wire logic           clk,
  input  wire logic           rst,
  pea_cmd_scheduler_if.master bus
);

  localparam int PW = log2(BUFFER_SIZE);

  pea_state_e             state_q,  state_d;
  logic [OP_W-1:0]        op_q,     op_d;
  logic [SLOT_W-1:0]      slot_q,   slot_d;
  logic [DEG_W-1:0]       n_q,      n_d;
  logic [1:0]             code_q,   code_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic [WORD_SIZE-1:0]   eval_x_q, eval_x_d;
  logic [2*WORD_SIZE-1:0] result_q, result_d;

  logic              ctl_rd, dat_rd, res_wr, st_wr, coef_wr, start;
  logic              tbl_wr, tbl_clr, tbl_valid;
  logic [SLOT_W-1:0] tbl_rd_slot;
  logic [DEG_W-1:0]  tbl_degree;
  logic [OP_W-1:0]   tok_op;
  logic [SLOT_W-1:0] tok_slot;
  logic [DEG_W-1:0]  tok_n;
  logic [PW-1:0]     stp_need;
  logic [CNT_W-1:0]  n_ext;

  assign tok_op   = bus.control_in[OP_LSB +: OP_W];
  assign tok_slot = bus.control_in[SLOT_LSB +: SLOT_W];
  assign tok_n    = bus.control_in[N_LSB +: DEG_W];
  assign n_ext    = {1'b0, n_q};
  assign stp_need = PW'(n_ext) + PW'(1);

  // DECODE looks up the incoming slot before it has been latched.
  assign tbl_rd_slot = (state_q == S_DECODE) ? tok_slot : slot_q;

  pea_slot_table u_slot_table (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (tbl_wr),
    .wr_slot_i   (slot_q),
    .wr_degree_i (n_q),
    .clr_i       (tbl_clr),
    .rd_slot_i   (tbl_rd_slot),
    .rd_valid_o  (tbl_valid),
    .rd_degree_o (tbl_degree)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      slot_q   <= '0;
      n_q      <= '0;
      code_q   <= '0;
      cnt_q    <= '0;
      eval_x_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      slot_q   <= slot_d;
      n_q      <= n_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      eval_x_q <= eval_x_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    slot_d   = slot_q;
    n_d      = n_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    eval_x_d = eval_x_q;
    result_d = result_q;
    ctl_rd   = 1'b0;
    dat_rd   = 1'b0;
    res_wr   = 1'b0;
    st_wr    = 1'b0;
    coef_wr  = 1'b0;
    start    = 1'b0;
    tbl_wr   = 1'b0;
    tbl_clr  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.control_pop != '0) state_d = S_FETCH;
      end
      S_FETCH: begin
        ctl_rd  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d   = tok_op;
        slot_d = tok_slot;
        n_d    = tok_n;
        cnt_d  = '0;
        code_d = ST_OK;
        case (tok_op)
          OP_STP: state_d = S_STP_WAIT;
          OP_EVP: begin
            if (tok_n == '0) begin
              state_d = S_STATUS;
            end else if (tbl_valid) begin
              state_d = S_EVP_WAIT;
            end else begin
              code_d  = ST_NOT_LOADED;
              state_d = S_DISC_WAIT;
            end
          end
          OP_CLR: begin
            tbl_clr = 1'b1;
            state_d = S_STATUS;
          end
          default: begin
            code_d  = ST_BAD_OP;
            state_d = S_STATUS;
          end
        endcase
      end
      // The whole coefficient set must be present before the first pop.
      S_STP_WAIT: begin
        if (bus.data_pop >= stp_need) state_d = S_STP_RD;
      end
      S_STP_RD: begin
        dat_rd  = 1'b1;
        state_d = S_STP_WR;
      end
      S_STP_WR: begin
        coef_wr = 1'b1;
        if (cnt_q == n_ext) begin
          tbl_wr  = 1'b1;
          state_d = S_STATUS;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_STP_RD;
        end
      end
      S_EVP_WAIT: begin
        if ((bus.data_pop != '0) && (bus.result_free_space != '0)) state_d = S_EVP_RD;
      end
      S_EVP_RD: begin
        dat_rd  = 1'b1;
        state_d = S_EVP_GO;
      end
      S_EVP_GO: begin
        start    = 1'b1;
        eval_x_d = bus.data_in;
        state_d  = S_EVP_RUN;
      end
      S_EVP_RUN: begin
        if (bus.eval_done) begin
          result_d = bus.eval_result;
          state_d  = S_EVP_WB;
        end
      end
      S_EVP_WB: begin
        res_wr  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_d == n_ext) ? S_STATUS : S_EVP_WAIT;
      end
      S_DISC_WAIT: begin
        if (bus.data_pop != '0) state_d = S_DISC_RD;
      end
      S_DISC_RD: begin
        dat_rd  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_d == n_ext) ? S_STATUS : S_DISC_WAIT;
      end
      S_STATUS: begin
        if (bus.status_free_space != '0) state_d = S_STAT_WR;
      end
      S_STAT_WR: begin
        st_wr   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.control_rd_en = ctl_rd;
  assign bus.data_rd_en    = dat_rd;
  assign bus.result_wr_en  = res_wr;
  assign bus.result_out    = result_q;
  assign bus.status_wr_en  = st_wr;
  assign bus.status_out    = {op_q, slot_q, 3'b000, code_q};
  assign bus.coef_wr_en    = coef_wr;
  assign bus.coef_slot     = slot_q;
  assign bus.coef_idx      = cnt_q[DEG_W-1:0];
  assign bus.coef_wdata    = (state_q == S_STP_WR) ? bus.data_in : '0;
  assign bus.eval_start    = start;
  assign bus.eval_slot     = slot_q;
  assign bus.eval_degree   = tbl_degree;
  // The popped x is forwarded in the start cycle and held from the register afterwards.
  assign bus.eval_x        = (state_q == S_EVP_GO) ? bus.data_in : eval_x_q;
  assign bus.busy          = (state_q != S_IDLE);

endmodule

`default_nettype wire
